// File: rtl/tiny_dnn_fwd_seq.sv
// tiny_dnn_fwd_seq -- forward-pass control sequencer for a chain of
// tiny_dnn_core accumulator slices.
//
// One pass: clear accumulators (init), stream len weight/input addresses
// (exec), optionally add the bias word (bias), wait two cycles for the core
// pipeline to flush, then parallel-load and shift n_out results to the tail.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse, accepted only when idle
//   len, bank,
//   bias_en, n_out    pass configuration, sampled on an accepted start
//   busy, done        pass in progress / one-cycle end-of-pass pulse
//   init, exec, bias  broadcast accumulator strobes to the cores
//   ra, da            weight read address {bank, index}, input buffer address
//   outr, update      sum-chain shift enable / parallel-load select
//   out_valid,
//   out_idx           tail result valid and its index (0 = last core)
module tiny_dnn_fwd_seq #(
  parameter int unsigned f_size = 1024,
  parameter int unsigned n_max  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(f_size):0]    len,
  input  logic                       bank,
  input  logic                       bias_en,
  input  logic [$clog2(n_max):0]     n_out,
  output logic                       busy,
  output logic                       done,
  output logic                       init,
  output logic                       exec,
  output logic                       bias,
  output logic [$clog2(f_size):0]    ra,
  output logic [$clog2(f_size)-1:0]  da,
  output logic                       outr,
  output logic                       update,
  output logic                       out_valid,
  output logic [$clog2(n_max)-1:0]   out_idx
);

  localparam int unsigned AW = $clog2(f_size);
  localparam int unsigned NW = $clog2(n_max);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_BIAS  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_LOAD  = 3'd5;
  localparam logic [2:0] S_SHIFT = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [AW:0] ONE_I = (AW+1)'(1);
  localparam logic [NW:0] ONE_J = (NW+1)'(1);

  logic [2:0]    r_state, w_state_nxt;
  logic [AW:0]   r_len, w_len_nxt;
  logic [AW:0]   r_i, w_i_nxt;        // exec index, reused as flush counter
  logic [NW:0]   r_nout, w_nout_nxt;
  logic [NW:0]   r_j, w_j_nxt;        // shift index
  logic          r_bank, w_bank_nxt;
  logic          r_bias_en, w_bias_en_nxt;

  logic          r_busy, r_done, r_init, r_exec, r_bias;
  logic          r_outr, r_update, r_out_valid;
  logic [AW:0]   r_ra;
  logic [AW-1:0] r_da;
  logic [NW-1:0] r_out_idx;

  logic          w_busy, w_done, w_init, w_exec, w_bias;
  logic          w_outr, w_update, w_out_valid;
  logic [AW:0]   w_ra;
  logic [AW-1:0] w_da;
  logic [NW-1:0] w_out_idx;

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_i_nxt       = r_i;
    w_nout_nxt    = r_nout;
    w_j_nxt       = r_j;
    w_bank_nxt    = r_bank;
    w_bias_en_nxt = r_bias_en;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_INIT;
          w_len_nxt     = len;
          w_bank_nxt    = bank;
          w_bias_en_nxt = bias_en;
          w_nout_nxt    = n_out;
        end
      end
      S_INIT: begin
        w_i_nxt = '0;
        if (r_len != '0)   w_state_nxt = S_EXEC;
        else if (r_bias_en) w_state_nxt = S_BIAS;
        else               w_state_nxt = S_FLUSH;
      end
      S_EXEC: begin
        if (r_i == r_len - ONE_I) begin
          w_i_nxt     = '0;
          w_state_nxt = r_bias_en ? S_BIAS : S_FLUSH;
        end else begin
          w_i_nxt = r_i + ONE_I;
        end
      end
      S_BIAS: begin
        w_i_nxt     = '0;
        w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (r_i == ONE_I) w_state_nxt = (r_nout != '0) ? S_LOAD : S_DONE;
        else              w_i_nxt = r_i + ONE_I;
      end
      S_LOAD: begin
        w_j_nxt     = '0;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_j == r_nout - ONE_J) w_state_nxt = S_DONE;
        else                       w_j_nxt = r_j + ONE_J;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // each output is a flop that lines up with the state it belongs to.
  always_comb begin
    w_busy      = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_done      = (w_state_nxt == S_DONE);
    w_init      = (w_state_nxt == S_INIT);
    w_exec      = (w_state_nxt == S_EXEC);
    w_bias      = (w_state_nxt == S_BIAS);
    w_update    = (w_state_nxt == S_LOAD);
    w_out_valid = (w_state_nxt == S_SHIFT);
    w_outr      = (w_state_nxt == S_LOAD) ||
                  ((w_state_nxt == S_SHIFT) && (w_j_nxt != r_nout - ONE_J));
    w_ra        = '0;
    w_da        = '0;
    w_out_idx   = '0;
    if (w_state_nxt == S_EXEC) begin
      w_ra = {r_bank, w_i_nxt[AW-1:0]};
      w_da = w_i_nxt[AW-1:0];
    end
    if (w_state_nxt == S_BIAS) w_ra = {r_bank, {AW{1'b0}}};
    if (w_state_nxt == S_SHIFT) w_out_idx = w_j_nxt[NW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_i         <= '0;
      r_nout      <= '0;
      r_j         <= '0;
      r_bank      <= 1'b0;
      r_bias_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_init      <= 1'b0;
      r_exec      <= 1'b0;
      r_bias      <= 1'b0;
      r_outr      <= 1'b0;
      r_update    <= 1'b0;
      r_out_valid <= 1'b0;
      r_ra        <= '0;
      r_da        <= '0;
      r_out_idx   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_i         <= w_i_nxt;
      r_nout      <= w_nout_nxt;
      r_j         <= w_j_nxt;
      r_bank      <= w_bank_nxt;
      r_bias_en   <= w_bias_en_nxt;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_init      <= w_init;
      r_exec      <= w_exec;
      r_bias      <= w_bias;
      r_outr      <= w_outr;
      r_update    <= w_update;
      r_out_valid <= w_out_valid;
      r_ra        <= w_ra;
      r_da        <= w_da;
      r_out_idx   <= w_out_idx;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign init      = r_init;
  assign exec      = r_exec;
  assign bias      = r_bias;
  assign ra        = r_ra;
  assign da        = r_da;
  assign outr      = r_outr;
  assign update    = r_update;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;

endmodule

// File: doc/tiny_dnn_fwd_seq.md
Name: tiny_dnn_fwd_seq

Overview:
- Upstream control sequencer for a chain of tiny_dnn_core accumulator slices. One forward pass runs as follows:
  - clears every slice's accumulator;
  - streams weight/input addresses for one dot product of length len;
  - optionally adds the bias word;
  - waits for the slice pipeline to flush;
  - drains the n_out results through the outr/update shift chain to the chain tail.
- Sits between the layer-level controller (start/done) and the broadcast control inputs of all cores.
- Also drives the read address of the shared input-activation buffer.

Parameters:
- f_size, 1024, weight bank depth per core; last entry (f_size-1) is reserved for bias; len must not exceed f_size-1.
- n_max, 1024, maximum number of chained cores drained per pass.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse, begins a pass when idle; ignored while busy.
- len  in  11  dot-product length, 0..f_size-1; sampled on accepted start.
- bank  in  1  weight bank select (W0/W1); sampled on start; driven as ra[10].
- bias_en  in  1  add bias word after the products; sampled on start.
- n_out  in  11  number of results to drain, 0..n_max; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at pass end.
- init  out  1  accumulator clear to cores.
- exec  out  1  multiply-accumulate strobe to cores.
- bias  out  1  bias-add strobe to cores.
- ra  out  11  weight read address {bank, index}.
- da  out  10  input buffer read address; the buffer has 1-cycle latency, so d is valid the cycle after da is driven.
- outr  out  1  shift/load enable of the core sum chain.
- update  out  1  selects parallel load (suml→sum) on the chain.
- out_valid  out  1  tail sum is a valid result this cycle.
- out_idx  out  10  index of the result at the tail (0 = last core in chain).

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0; latched len/bank/bias_en/n_out cleared. Reset mid-pass abandons the pass; core accumulators are not cleared by reset, and the next pass starts with INIT.
- All outputs are registered (driven from state/counter flops, no combinational paths from inputs).
- States:
  - IDLE: start=1 → INIT, latch config, busy=1.
  - INIT: init=1 for 1 cycle. Next state is EXEC if len>0, else BIAS if bias_en, else FLUSH.
  - EXEC: len cycles, counter i=0..len-1; exec=1, ra={bank,i}, da=i. After i=len-1, next state is BIAS if bias_en, else FLUSH.
  - BIAS: bias=1 for 1 cycle, ra={bank,10'd0}; the core substitutes the bias address internally. → FLUSH.
  - FLUSH: exactly 2 cycles, all strobes 0. Covers the core's 3-stage exec→suml latency. → LOAD if n_out>0, else DONE.
  - LOAD: update=1, outr=1 for 1 cycle, which parallel-loads every core's suml into its sumt. → SHIFT.
  - SHIFT: n_out cycles, counter j=0..n_out-1. out_valid=1 and out_idx=j in every cycle. outr=1 for j<n_out-1 and 0 on the last cycle; update=0 throughout. → DONE.
  - DONE: done=1 and busy=0 for 1 cycle (busy falls in this cycle). → IDLE. start is accepted again from IDLE in the next cycle.
- Exec/bias/init are never asserted in the same cycle; init always precedes the first exec by ≥1 cycle.
- Pass length in cycles from accepted start to done: 1 + len + bias_en + 2 + (n_out>0 ? 1+n_out : 0) + 1.
- start during busy, including the DONE cycle: ignored, no queuing.
- Boundaries:
  - len=0 with bias_en=0: the result is 0.
  - n_out=0: no outr/update/out_valid at all.
  - n_out=1: outr only in LOAD.
  - Counters are 11-bit, with no wrap within legal ranges. Values above the legal limits (len > f_size-1, n_out > n_max) are undefined use.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC (len=8, i=3) → all outputs 0 in the same cycle; after release, IDLE. A new start with len=2 gives init, then exec with ra=0,1.
- Basic pass: len=4, bank=1, bias_en=0, n_out=3 → init at cycle 1; exec cycles 2-5 with ra=0x400..0x403 and da=0..3; 2 idle cycles; LOAD with update=outr=1; SHIFT 3 cycles with outr=1,1,0 and out_idx=0,1,2; done at cycle 12.
- Bias path: len=2, bias_en=1, n_out=1 → bias=1 exactly one cycle after the last exec, with ra[10]=bank. With a 1-core model (w=2,3, d=1,1, bias=5), the tail value is 10 when out_valid=1.
- Degenerate: len=0, bias_en=0, n_out=0 → init, 2 flush cycles, done; no exec, no outr.
- Start collision: pulse start during EXEC and again during DONE → both ignored, busy/done timing unchanged; start in the cycle after done is accepted.
- Chain drain with 4 core models holding 1.0, 2.0, 3.0, 4.0 and n_out=4 → tail emits 4.0, 3.0, 2.0, 1.0 on out_idx 0..3.
